// File: rtl/matrix_loader.sv
// matrix_loader: packs a valid/ready byte stream into DIM*DIM-element matrix
// words and writes them to the shared operand memory at consecutive
// addresses starting from a latched base.
module matrix_loader #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 5,
  parameter int ADDR_W = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic [3:0]                  num_words,
  input  logic [ELEM_W-1:0]           byte_in,
  input  logic                        byte_valid,
  output logic                        byte_ready,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [ELEM_W*DIM*DIM-1:0]   mem_data_out,
  output logic                        mem_wren,
  output logic                        busy,
  output logic                        done
);

  localparam int WORD_W = ELEM_W * DIM * DIM;
  localparam int NBEATS = DIM * DIM;
  localparam int BEAT_W = $clog2(NBEATS);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t              state, state_nx;
  logic [BEAT_W-1:0]   beat_q;
  logic [3:0]          word_q;
  logic [3:0]          num_q;
  logic [ADDR_W-1:0]   base_q;
  logic [WORD_W-1:0]   shreg_q;
  logic                last_beat;
  logic [WORD_W-1:0]   packed_word;

  assign last_beat   = (beat_q == BEAT_W'(NBEATS - 1));
  // New beats enter at the top and shift down, so after NBEATS transfers the
  // first beat sits in the lowest element slot.
  assign packed_word = {byte_in, shreg_q[WORD_W-1:ELEM_W]};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (num_words == 4'd0) ? DONE : COLLECT;
      COLLECT: if (byte_valid && last_beat) state_nx = WRITE;
      WRITE:   state_nx = ({1'b0, word_q} + 5'd1 == {1'b0, num_q}) ? DONE : COLLECT;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control outputs decoded from the current state
  always_comb begin
    byte_ready = (state == COLLECT);
    mem_wren   = (state == WRITE);
    busy       = (state == COLLECT) || (state == WRITE);
    done       = (state == DONE);
  end

  // Datapath: parameter latch, beat/word counters, packing and write registers
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q       <= '0;
      num_q        <= '0;
      beat_q       <= '0;
      word_q       <= '0;
      shreg_q      <= '0;
      mem_address  <= '0;
      mem_data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            num_q  <= num_words;
            beat_q <= '0;
            word_q <= '0;
          end
        end
        COLLECT: begin
          if (byte_valid && byte_ready) begin
            shreg_q <= packed_word;
            if (last_beat) begin
              // Word and address are registered on the final beat so they are
              // already stable for the whole WRITE cycle and held afterwards.
              beat_q       <= '0;
              mem_data_out <= packed_word;
              mem_address  <= base_q + ADDR_W'(word_q);
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        WRITE: begin
          word_q <= word_q + 4'd1;
          beat_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/matrix_loader.md
Name: matrix_loader

Overview:
Host-side writer for the coprocessor's operand memory. It accepts a byte stream over a valid/ready handshake and packs each group of 25 bytes into one 200-bit 5x5 matrix word. It writes each word into the shared memory interface at consecutive addresses starting at a programmed base. It drives the same address, write-data and write-enable signals that the coprocessor drives for write-back, and is muxed onto the memory while the coprocessor is idle.

Parameters:
ELEM_W, 8, bits per matrix element (one stream beat).
DIM, 5, matrix dimension; one word holds DIM*DIM elements.
ADDR_W, 8, memory address width.
(Derived: WORD_W = ELEM_W*DIM*DIM = 200; NBEATS = DIM*DIM = 25.)

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse that launches a load; sampled only in IDLE.
base_addr  in  ADDR_W  first memory address; latched on the accepted start.
num_words  in  4  number of matrices to load (0..15); latched on the accepted start.
byte_in  in  ELEM_W  stream element.
byte_valid  in  1  byte_in holds valid data.
byte_ready  out  1  loader can accept a beat this cycle.
mem_address  out  ADDR_W  memory address.
mem_data_out  out  WORD_W  packed matrix word.
mem_wren  out  1  memory write strobe, one cycle per word.
busy  out  1  high from the accepted start until done.
done  out  1  one-cycle pulse when the load completes.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: state=IDLE; byte_ready=0, mem_wren=0, busy=0, done=0; mem_address=0, mem_data_out=0. Internal beat counter, word counter and shift register are all cleared.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - byte_ready=0.
  - start=1 latches base_addr and num_words, sets busy=1.
  - If num_words=0, go to DONE. Otherwise go to COLLECT with beat=0 and word=0.
- COLLECT:
  - byte_ready=1.
  - A beat transfers when byte_valid & byte_ready.
  - Beat k (0..24) is placed at bits [8k+7:8k]. Element (r,c) = beat r*5+c, so bits 7:0 hold element (0,0) and bits 199:192 hold element (4,4).
  - On the 25th transfer (beat=24), go to WRITE.
  - Cycles without a transfer stall with no state change.
- WRITE (exactly one cycle):
  - byte_ready=0, mem_wren=1.
  - mem_address = (base + word) mod 2^ADDR_W; the address wraps from 255 to 0.
  - mem_data_out = the packed word, held stable through this cycle.
  - Then word increments and beat clears. If word+1 = num_words, go to DONE; else go to COLLECT.
- DONE (one cycle):
  - done=1; busy drops to 0 in the same cycle.
  - Next state is IDLE.
- Latency:
  - With byte_valid held high, word n's write strobe occurs 25 cycles after its first beat is accepted.
  - One word costs 26 cycles.
  - The first beat can be accepted in the cycle after start.
- mem_data_out and mem_address hold their last values outside WRITE; only mem_wren qualifies them. mem_wren is never high outside WRITE.
- start while busy: ignored, and the latched parameters do not change.
- byte_valid in IDLE, WRITE or DONE: not accepted, because byte_ready=0. The upstream source must hold its data.
- Reset mid-load returns to IDLE with no write. A beat or strobe in the reset cycle has no effect. The partial word is discarded.
- Start asserted in the same cycle as reset: reset wins.

Test Plan:
- Reset, then idle: reset for 2 cycles -> all outputs 0; byte_ready=0 while idle with byte_valid=1.
- Single word: start with base=0x10, num_words=1, then bytes 0x01..0x19 back to back -> one mem_wren pulse 25 cycles after the first beat. Required: address 0x10, data[7:0]=0x01, data[199:192]=0x19; done pulses the next cycle; busy spans start+1 through done.
- Multiple words with wrap: base=0xFE, num_words=3, 75 bytes -> three strobes at addresses 0xFE, 0xFF, 0x00, each word packed correctly. byte_ready=0 in each WRITE cycle.
- Backpressure/gaps: byte_valid toggles 1,0,0,1 randomly over 25 beats -> only handshaken beats are captured; the packed word equals the 25 valid bytes in order.
- Zero count and busy start: num_words=0 -> done the cycle after IDLE with no mem_wren. A start pulse mid-load with base=0x80 is ignored; later addresses still follow the original base.
- Reset mid-operation: reset after 12 beats -> no mem_wren. A new load afterwards with fresh bytes packs from beat 0, with no stale bytes.
